// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- dual-issue write-back pipeline stage.
//
// Purpose:
//   Holds one W-stage register per lane, capturing the lane's M-stage
//   results. From the registered contents it produces the register-file
//   write ports. Load data is extracted here: byte, halfword or word,
//   sign- or zero-extended. When both lanes target the same register,
//   the younger lane (lane 2) wins.
//
// Configuration:
//   WB_RETIRE_CNT_EN -- when defined, adds a 32-bit retired-instruction
//                       counter and its output port retire_cnt.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallW, flushW           hold W contents / load a bubble into W
//   validM1/2, regwriteM1/2  lane present / lane writes a register
//   memtoregM1/2             result is load data (1) or ALU result (0)
//   waM1/2                   destination register
//   aluoutM1/2               ALU result or load byte address
//   readdataM1/2             raw aligned memory word
//   ldtypeM1/2               000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
//   we13/23, wa13/23, wd13/23  register-file write ports, lane 1 / lane 2
//   retire_cnt               retired-instruction count (optional)
// ---------------------------------------------------------------------------
module wb_stage (
   input  logic        clk,
   input  logic        rst,
`ifdef WB_RETIRE_CNT_EN
   output logic [31:0] retire_cnt,
`endif
   input  logic        stallW,
   input  logic        flushW,
   input  logic        validM1,
   input  logic        validM2,
   input  logic        regwriteM1,
   input  logic        regwriteM2,
   input  logic        memtoregM1,
   input  logic        memtoregM2,
   input  logic [4:0]  waM1,
   input  logic [4:0]  waM2,
   input  logic [31:0] aluoutM1,
   input  logic [31:0] aluoutM2,
   input  logic [31:0] readdataM1,
   input  logic [31:0] readdataM2,
   input  logic [2:0]  ldtypeM1,
   input  logic [2:0]  ldtypeM2,
   output logic        we13,
   output logic        we23,
   output logic [4:0]  wa13,
   output logic [4:0]  wa23,
   output logic [31:0] wd13,
   output logic [31:0] wd23
);

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic        memtoreg;
      logic [4:0]  wa;
      logic [31:0] aluout;
      logic [31:0] readdata;
      logic [2:0]  ldtype;
   } w_lane_t;

   localparam w_lane_t LANE_CLEAR = '0;

   w_lane_t w1_q, w1_d;
   w_lane_t w2_q, w2_d;
   w_lane_t m1, m2;

   logic we1_raw, we2_raw;

   // Selects the byte/halfword/word named by the load type and address,
   // then extends it to 32 bits. Unused ldtype codes behave as lw.
   function automatic logic [31:0] extract_load(input logic [2:0]  ldtype,
                                                input logic [1:0]  addr,
                                                input logic [31:0] word);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      logic [31:0] result;
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];
      case (ldtype)
         3'b001:  result = {{24{byte_sel[7]}}, byte_sel};
         3'b010:  result = {24'd0, byte_sel};
         3'b011:  result = {{16{half_sel[15]}}, half_sel};
         3'b100:  result = {16'd0, half_sel};
         default: result = word;
      endcase
      return result;
   endfunction

   // Bundle the M-stage inputs per lane so the capture logic reads as one
   // register update instead of seven.
   always_comb begin
      m1 = '{validM1, regwriteM1, memtoregM1, waM1, aluoutM1, readdataM1, ldtypeM1};
      m2 = '{validM2, regwriteM2, memtoregM2, waM2, aluoutM2, readdataM2, ldtypeM2};
   end

   // Next-state for the W registers. Reset beats flush, and flush beats
   // stall. A flush only clears the valid bits; the remaining fields are
   // held because they are don't-care once the lane is invalid.
   always_comb begin
      w1_d = w1_q;
      w2_d = w2_q;
      if (rst) begin
         w1_d = LANE_CLEAR;
         w2_d = LANE_CLEAR;
      end else if (flushW) begin
         w1_d.valid = 1'b0;
         w2_d.valid = 1'b0;
      end else if (!stallW) begin
         w1_d = m1;
         w2_d = m2;
      end
   end

   // W-stage register bank; reset is applied through w*_d.
   always_ff @(posedge clk) begin
      w1_q <= w1_d;
      w2_q <= w2_d;
   end

   // Write-port generation. Register 0 is never written. When both lanes
   // hit the same register, lane 1's write is suppressed so the younger
   // result lands.
   always_comb begin
      we1_raw = w1_q.valid & w1_q.regwrite & (w1_q.wa != 5'd0);
      we2_raw = w2_q.valid & w2_q.regwrite & (w2_q.wa != 5'd0);
      we13    = we1_raw & ~(we2_raw & (w1_q.wa == w2_q.wa));
      we23    = we2_raw;
      wa13    = w1_q.wa;
      wa23    = w2_q.wa;
      wd13    = w1_q.memtoreg ? extract_load(w1_q.ldtype, w1_q.aluout[1:0], w1_q.readdata)
                              : w1_q.aluout;
      wd23    = w2_q.memtoreg ? extract_load(w2_q.ldtype, w2_q.aluout[1:0], w2_q.readdata)
                              : w2_q.aluout;
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q, retire_cnt_d;

   // Retirement happens when an instruction leaves W, so the count adds
   // the valid bits currently in W on every non-stalled edge. This still
   // counts instructions being flushed out. Bubbles loaded by a flush are
   // not counted because their valid bits are cleared.
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (rst) begin
         retire_cnt_d = 32'd0;
      end else if (!stallW) begin
         retire_cnt_d = retire_cnt_q + {31'd0, w1_q.valid} + {31'd0, w2_q.valid};
      end
   end

   // Counter register; wraps naturally modulo 2^32.
   always_ff @(posedge clk) begin
      retire_cnt_q <= retire_cnt_d;
   end

   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Directed literal checks pin the expected behaviour. A behavioural model
// of the W registers is checked against the DUT on every falling edge
// during directed and randomized stimulus.
// ---------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallW, flushW;
   logic        validM1, validM2, regwriteM1, regwriteM2, memtoregM1, memtoregM2;
   logic [4:0]  waM1, waM2;
   logic [31:0] aluoutM1, aluoutM2, readdataM1, readdataM2;
   logic [2:0]  ldtypeM1, ldtypeM2;
   logic        we13, we23;
   logic [4:0]  wa13, wa23;
   logic [31:0] wd13, wd23;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   int compareCnt  = 0;
   int mismatchCnt = 0;
   bit checkEn     = 1'b0;

   // Model of the W registers, kept as per-lane arrays.
   bit          mValid[2], mRegwrite[2], mMemtoreg[2];
   logic [4:0]  mWa[2];
   logic [31:0] mAlu[2], mRd[2];
   logic [2:0]  mLt[2];
   logic [31:0] mCnt;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk),
      .rst(rst),
`ifdef WB_RETIRE_CNT_EN
      .retire_cnt(retire_cnt),
`endif
      .stallW(stallW),
      .flushW(flushW),
      .validM1(validM1),
      .validM2(validM2),
      .regwriteM1(regwriteM1),
      .regwriteM2(regwriteM2),
      .memtoregM1(memtoregM1),
      .memtoregM2(memtoregM2),
      .waM1(waM1),
      .waM2(waM2),
      .aluoutM1(aluoutM1),
      .aluoutM2(aluoutM2),
      .readdataM1(readdataM1),
      .readdataM2(readdataM2),
      .ldtypeM1(ldtypeM1),
      .ldtypeM2(ldtypeM2),
      .we13(we13),
      .we23(we23),
      .wa13(wa13),
      .wa23(wa23),
      .wd13(wd13),
      .wd23(wd23)
   );

   // Computes load data by shifting the memory word and testing the sign bit.
   function automatic logic [31:0] expData(bit mr, logic [2:0] lt,
                                           logic [31:0] alu, logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * alu[1:0])) & 32'hFF;
      h = (rd >> (16 * alu[1])) & 32'hFFFF;
      if (!mr) return alu;
      case (lt)
         3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return h;
         default: return rd;
      endcase
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      compareCnt++;
      if (act !== exp) begin
         mismatchCnt++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(int lane, bit v, bit rw, bit mr, logic [4:0] wa,
                                logic [31:0] alu, logic [31:0] rd, logic [2:0] lt);
      if (lane == 1) begin
         validM1 = v; regwriteM1 = rw; memtoregM1 = mr; waM1 = wa;
         aluoutM1 = alu; readdataM1 = rd; ldtypeM1 = lt;
      end else begin
         validM2 = v; regwriteM2 = rw; memtoregM2 = mr; waM2 = wa;
         aluoutM2 = alu; readdataM2 = rd; ldtypeM2 = lt;
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic idleLanes();
      applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0);
      applyStimulus(2, 0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0);
   endtask

   // Reference model update, following the stage rules directly.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mValid[i] = 0; mRegwrite[i] = 0; mMemtoreg[i] = 0;
            mWa[i] = '0; mAlu[i] = '0; mRd[i] = '0; mLt[i] = '0;
         end
         mCnt = 32'd0;
      end else begin
         if (!stallW) mCnt = mCnt + 32'(mValid[0]) + 32'(mValid[1]);
         if (flushW) begin
            mValid[0] = 0;
            mValid[1] = 0;
         end else if (!stallW) begin
            mValid[0] = validM1; mRegwrite[0] = regwriteM1; mMemtoreg[0] = memtoregM1;
            mWa[0] = waM1; mAlu[0] = aluoutM1; mRd[0] = readdataM1; mLt[0] = ldtypeM1;
            mValid[1] = validM2; mRegwrite[1] = regwriteM2; mMemtoreg[1] = memtoregM2;
            mWa[1] = waM2; mAlu[1] = aluoutM2; mRd[1] = readdataM2; mLt[1] = ldtypeM2;
         end
      end
   end

   // Compare the DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         bit e1, e2;
         e1 = mValid[0] && mRegwrite[0] && (mWa[0] != 0);
         e2 = mValid[1] && mRegwrite[1] && (mWa[1] != 0);
         if (e1 && e2 && mWa[0] == mWa[1]) e1 = 0;
         checkOutput("model we13", 32'(we13), 32'(e1));
         checkOutput("model we23", 32'(we23), 32'(e2));
         checkOutput("model wa13", 32'(wa13), 32'(mWa[0]));
         checkOutput("model wa23", 32'(wa23), 32'(mWa[1]));
         checkOutput("model wd13", wd13, expData(mMemtoreg[0], mLt[0], mAlu[0], mRd[0]));
         checkOutput("model wd23", wd23, expData(mMemtoreg[1], mLt[1], mAlu[1], mRd[1]));
`ifdef WB_RETIRE_CNT_EN
         checkOutput("model retire_cnt", retire_cnt, mCnt);
`endif
      end
   end

   initial begin
      rst = 1; stallW = 0; flushW = 0;
      idleLanes();
      stepClk();
      stepClk();
      checkEn = 1;
      checkOutput("reset we13", 32'(we13), 32'd0);
      checkOutput("reset we23", 32'(we23), 32'd0);
      checkOutput("reset wa13", 32'(wa13), 32'd0);
      checkOutput("reset wd23", wd23, 32'd0);
`ifdef WB_RETIRE_CNT_EN
      checkOutput("reset retire_cnt", retire_cnt, 32'd0);
`endif
      rst = 0;

      // Simple ALU write on lane 1.
      applyStimulus(1, 1, 1, 0, 5'd8, 32'h1234, 32'h0, 3'd0);
      stepClk();
      checkOutput("alu we13", 32'(we13), 32'd1);
      checkOutput("alu wa13", 32'(wa13), 32'd8);
      checkOutput("alu wd13", wd13, 32'h00001234);
      checkOutput("alu we23", 32'(we23), 32'd0);

      // Load extraction on lane 1.
      applyStimulus(1, 1, 1, 1, 5'd9, 32'h103, 32'h80FF7F01, 3'd1);
      stepClk();
      checkOutput("lb", wd13, 32'hFFFFFF80);
      applyStimulus(1, 1, 1, 1, 5'd9, 32'h103, 32'h80FF7F01, 3'd2);
      stepClk();
      checkOutput("lbu", wd13, 32'h00000080);
      applyStimulus(1, 1, 1, 1, 5'd9, 32'h102, 32'h80FF7F01, 3'd3);
      stepClk();
      checkOutput("lh", wd13, 32'hFFFF80FF);
      applyStimulus(1, 1, 1, 1, 5'd9, 32'h102, 32'h80FF7F01, 3'd4);
      stepClk();
      checkOutput("lhu", wd13, 32'h000080FF);
      applyStimulus(1, 1, 1, 1, 5'd9, 32'h103, 32'h80FF7F01, 3'd0);
      stepClk();
      checkOutput("lw", wd13, 32'h80FF7F01);

      // WAW override, then both lanes writing register 0.
      applyStimulus(1, 1, 1, 0, 5'd5, 32'hA, 32'h0, 3'd0);
      applyStimulus(2, 1, 1, 0, 5'd5, 32'hB, 32'h0, 3'd0);
      stepClk();
      checkOutput("waw we13", 32'(we13), 32'd0);
      checkOutput("waw we23", 32'(we23), 32'd1);
      checkOutput("waw wd23", wd23, 32'h0000000B);
      applyStimulus(1, 1, 1, 0, 5'd0, 32'hA, 32'h0, 3'd0);
      applyStimulus(2, 1, 1, 0, 5'd0, 32'hB, 32'h0, 3'd0);
      stepClk();
      checkOutput("r0 we13", 32'(we13), 32'd0);
      checkOutput("r0 we23", 32'(we23), 32'd0);

      // Stall holds lane 2 contents while M changes; stall+flush clears.
      applyStimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
      applyStimulus(2, 1, 1, 0, 5'd3, 32'h77, 32'h0, 3'd0);
      stepClk();
      stallW = 1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2, 1, 1, 0, 5'($urandom_range(4, 31)), $urandom, $urandom, 3'd0);
         stepClk();
         checkOutput("stall wa23", 32'(wa23), 32'd3);
         checkOutput("stall wd23", wd23, 32'h77);
      end
      flushW = 1;
      stepClk();
      checkOutput("flush we13", 32'(we13), 32'd0);
      checkOutput("flush we23", 32'(we23), 32'd0);
      flushW = 0;

      // Reset during a stall discards the held instruction.
      stallW = 0;
      applyStimulus(1, 1, 1, 0, 5'd7, 32'h55, 32'h0, 3'd0);
      stepClk();
      stallW = 1;
      rst = 1;
      stepClk();
      checkOutput("rst-stall we13", 32'(we13), 32'd0);
      rst = 0; stallW = 0;
      idleLanes();
      stepClk();

`ifdef WB_RETIRE_CNT_EN
      // Four dual captures, one stall, one flush: eight retirements.
      rst = 1;
      stepClk();
      rst = 0;
      applyStimulus(1, 1, 1, 0, 5'd1, 32'h1, 32'h0, 3'd0);
      applyStimulus(2, 1, 1, 0, 5'd2, 32'h2, 32'h0, 3'd0);
      for (int i = 0; i < 4; i++) stepClk();
      stallW = 1;
      stepClk();
      stallW = 0; flushW = 1;
      stepClk();
      flushW = 0;
      checkOutput("retire eight", retire_cnt, 32'd8);
      rst = 1;
      stepClk();
      checkOutput("retire reset", retire_cnt, 32'd0);
      rst = 0;
      idleLanes();
`endif

      // Randomized traffic; small address range forces collisions.
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 49) == 0);
         stallW = ($urandom_range(0, 4) == 0);
         flushW = ($urandom_range(0, 7) == 0);
         applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       $urandom, $urandom, 3'($urandom_range(0, 7)));
         applyStimulus(2, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       $urandom, $urandom, 3'($urandom_range(0, 7)));
         stepClk();
      end
      rst = 0; stallW = 0; flushW = 0;
      stepClk();
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter none; all widths fixed (32-bit data, 5-bit register address).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallW  input  1  hold W-stage contents.
REQ-005 flushW  input  1  load a bubble into W instead of M-stage values.
REQ-006 validM1, validM2  input  1 each  lane 1 (older) / lane 2 (younger) instruction present in M.
REQ-007 regwriteM1, regwriteM2  input  1 each  lane writes a register.
REQ-008 memtoregM1, memtoregM2  input  1 each  result is load data (1) or ALU result (0).
REQ-009 waM1, waM2  input  5 each  destination register.
REQ-010 aluoutM1, aluoutM2  input  32 each  ALU result / load byte address.
REQ-011 readdataM1, readdataM2  input  32 each  raw aligned memory word.
REQ-012 ldtypeM1, ldtypeM2  input  3 each  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101-111 treated as lw.
REQ-013 we13, we23  output  1 each  register-file write enables, lane 1 / lane 2.
REQ-014 wa13, wa23  output  5 each  register-file write addresses.
REQ-015 wd13, wd23  output  32 each  register-file write data.
REQ-016 retire_cnt  output  32  retired-instruction count (present only per REQ-031).

Function
REQ-017 SHALL hold one W register per lane capturing valid, regwrite, memtoreg, wa, aluout, readdata, ldtype; latency M->outputs exactly one clock.
REQ-018 Per rising edge, not in reset: flushW=1 -> both W valids cleared (other fields don't-care); else stallW=1 -> all W fields held; else all W fields load from M inputs. flushW SHALL take priority over stallW.
REQ-019 Outputs SHALL be combinational from W registers only; no M input reaches an output combinationally.
REQ-020 weX3 SHALL equal validWX & regwriteWX & (waWX != 0); waX3 = waWX always.
REQ-021 WAW override: if both lanes would assert we and waW1 == waW2, we13 SHALL be 0 and we23 1 (younger lane wins).
REQ-022 wdX3 = aluoutWX when memtoregWX=0; else extracted load data per REQ-023..025.
REQ-023 Byte loads: byte lane = aluout[1:0], little-endian (0 -> bits 7:0, 3 -> bits 31:24); lb sign-extends, lbu zero-extends to 32 bits.
REQ-024 Halfword loads: aluout[1]=0 -> bits 15:0, 1 -> bits 31:16; aluout[0] ignored; lh sign-extends, lhu zero-extends.
REQ-025 Word loads: wd = readdata unchanged; aluout[1:0] ignored.
REQ-026 While stallW=1 outputs SHALL remain stable; repeated identical register writes are permitted.

Reset
REQ-027 rst=1 at a rising edge SHALL clear both W valids and all other W fields to 0, overriding flushW and stallW.
REQ-028 During and after reset until the first capture: we13=0, we23=0, wa13=wa23=0, wd13=wd23=0, retire_cnt=0.
REQ-029 Reset asserted mid-stall SHALL discard held contents; no write enable asserts in the following cycle.

Configuration
REQ-030 Macro WB_RETIRE_CNT_EN SHALL control the retire counter.
REQ-031 Defined: retire_cnt port exists; each rising edge with rst=0 and stallW=0 adds (validW1 + validW2) (0, 1 or 2), wraps modulo 2^32; flushed-in bubbles not counted; instructions already in W when flushW asserts still counted. Not defined: port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset then lane1 M: valid=1, regwrite=1, wa=8, aluout=0x1234, memtoreg=0 -> next cycle we13=1, wa13=8, wd13=0x00001234, we23=0.
REQ-033 Lane1 lb with aluout=0x103, readdata=0x80FF7F01 -> wd13=0xFFFFFF80; same with lbu -> 0x00000080; lh aluout=0x102 -> 0xFFFF80FF; lhu -> 0x000080FF.
REQ-034 Both lanes valid, regwrite, wa=5, wd 0xA and 0xB -> we13=0, we23=1, wd23=0x0000000B; with wa=0 both -> we13=we23=0.
REQ-035 Capture lane2 wa=3 data 0x77, then stallW=1 three cycles while M changes -> outputs hold wa23=3, wd23=0x77; stallW=1 and flushW=1 same edge -> we13=we23=0 next cycle.
REQ-036 WB_RETIRE_CNT_EN defined: 4 dual-valid captures, one stalled cycle, one flush bubble -> retire_cnt=8; rst mid-stream -> retire_cnt=0 next cycle; preload to 0xFFFFFFFF then one dual-valid retire -> 0x00000001.
